// File: rtl/jacobian_to_affine.sv
// jacobian_to_affine: converts a Jacobian point (X, Y) plus zinv = Z^-1 mod M
// into affine coordinates x = X*zinv^2 mod M, y = Y*zinv^3 mod M.
//
// One bit-serial interleaved modular multiplier is reused for four products:
//   T = zinv*zinv, x = X*T, T = T*zinv, y = Y*T
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready request handshake (ready only while idle)
//   opX, opY, opZinv  Jacobian X, Y and Z^-1, all expected < opM
//   opM               field modulus, 2 <= opM < 2^DATA_WIDTH
//   out_x, out_y      affine result, held until the next result or reset
//   out_valid         one-cycle pulse marking a fresh result
module jacobian_to_affine #(
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] opX,
    input  logic [DATA_WIDTH-1:0] opY,
    input  logic [DATA_WIDTH-1:0] opZinv,
    input  logic [DATA_WIDTH-1:0] opM,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic                  out_valid
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    x_q;
    logic [W-1:0]    y_q;
    logic [W-1:0]    z_q;
    logic [W-1:0]    m_q;
    logic [W-1:0]    t_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    acc_d;
    logic [CW-1:0]   bit_cnt_q;
    logic [1:0]      op_idx_q;
    logic [W-1:0]    out_x_q;
    logic [W-1:0]    out_y_q;
    logic            out_valid_q;

    logic [W-1:0]    mul_a;
    logic [W-1:0]    mul_b;
    logic [W+1:0]    addend;
    logic [W+1:0]    sum;
    logic [W+1:0]    red1;
    logic [W+1:0]    red2;
    logic [W+1:0]    m_ext;

    assign in_ready  = (state_q == S_IDLE);
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_valid = out_valid_q;

    // Operand routing for the four chained products.
    always_comb begin
        mul_a = z_q;
        mul_b = z_q;
        unique case (op_idx_q)
            2'd0: begin
                mul_a = z_q;
                mul_b = z_q;
            end
            2'd1: begin
                mul_a = x_q;
                mul_b = t_q;
            end
            2'd2: begin
                mul_a = t_q;
                mul_b = z_q;
            end
            2'd3: begin
                mul_a = y_q;
                mul_b = t_q;
            end
        endcase
    end

    // One MSB-first step: 2*acc + (bit ? b : 0) is below 3M when acc, b < M,
    // so two conditional subtractions bring it back under M.
    always_comb begin
        m_ext  = {2'b00, m_q};
        addend = mul_a[bit_cnt_q] ? {2'b00, mul_b} : '0;
        sum    = {1'b0, acc_q, 1'b0} + addend;
        red1   = (sum >= m_ext) ? (sum - m_ext) : sum;
        red2   = (red1 >= m_ext) ? (red1 - m_ext) : red1;
        acc_d  = red2[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            m_q         <= '0;
            t_q         <= '0;
            acc_q       <= '0;
            bit_cnt_q   <= '0;
            op_idx_q    <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q       <= opX;
                        y_q       <= opY;
                        z_q       <= opZinv;
                        m_q       <= opM;
                        op_idx_q  <= 2'd0;
                        bit_cnt_q <= LAST_BIT;
                        acc_q     <= '0;
                        state_q   <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (bit_cnt_q == '0) begin
                        acc_q     <= '0;
                        bit_cnt_q <= LAST_BIT;
                        op_idx_q  <= op_idx_q + 2'd1;
                        unique case (op_idx_q)
                            2'd0: t_q <= acc_d;
                            2'd1: out_x_q <= acc_d;
                            2'd2: t_q <= acc_d;
                            2'd3: begin
                                out_y_q <= acc_d;
                                state_q <= S_DONE;
                            end
                        endcase
                    end else begin
                        acc_q     <= acc_d;
                        bit_cnt_q <= bit_cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    // Registered, so the pulse appears in the cycle after DONE.
                    out_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jacobian_to_affine.sv
// tb_jacobian_to_affine: directed and random checks of jacobian_to_affine
// at W=8 (M=251) and W=256 (P-256) against plain modular arithmetic.
module tb_jacobian_to_affine;

    localparam logic [255:0] P256 =
        256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       v8, r8, ov8;
    logic [7:0] x8, y8, z8, m8, ox8, oy8;

    logic         v2, r2, ov2;
    logic [255:0] x2, y2, z2, m2, ox2, oy2;

    int checks = 0;
    int errors = 0;

    jacobian_to_affine #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(v8), .in_ready(r8),
        .opX(x8), .opY(y8), .opZinv(z8), .opM(m8),
        .out_x(ox8), .out_y(oy8), .out_valid(ov8)
    );

    jacobian_to_affine #(.DATA_WIDTH(256)) dut256 (
        .clk(clk), .rst(rst),
        .in_valid(v2), .in_ready(r2),
        .opX(x2), .opY(y2), .opZinv(z2), .opM(m2),
        .out_x(ox2), .out_y(oy2), .out_valid(ov2)
    );

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: (a*b) mod m with full-width product.
    function automatic logic [255:0] mm(input logic [255:0] a,
                                        input logic [255:0] b,
                                        input logic [255:0] m);
        logic [511:0] p;
        p = ({256'b0, a} * {256'b0, b}) % {256'b0, m};
        return p[255:0];
    endfunction

    function automatic logic [255:0] ref_x(input logic [255:0] x,
                                           input logic [255:0] z,
                                           input logic [255:0] m);
        return mm(x, mm(z, z, m), m);
    endfunction

    function automatic logic [255:0] ref_y(input logic [255:0] y,
                                           input logic [255:0] z,
                                           input logic [255:0] m);
        return mm(y, mm(mm(z, z, m), z, m), m);
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return r % P256;
    endfunction

    // Issue one W=8 request and count edges from accept to out_valid.
    task automatic run8(input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] z, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!r8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        x8 = x;
        y8 = y;
        z8 = z;
        v8 = 1'b1;
        @(posedge clk);
        #1 v8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run256(input logic [255:0] x, input logic [255:0] y,
                          input logic [255:0] z, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!r2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        x2 = x;
        y2 = y;
        z2 = z;
        v2 = 1'b1;
        @(posedge clk);
        #1 v2 = 1'b0;
        lat = 0;
        while (!ov2 && lat < 1100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int n;
        bit seen;
        logic [7:0] a, b, c;
        logic [255:0] ax, ay, az;

        rst = 1'b1;
        v8 = 1'b0; x8 = '0; y8 = '0; z8 = '0; m8 = 8'd251;
        v2 = 1'b0; x2 = '0; y2 = '0; z2 = '0; m2 = P256;
        #3;
        chk("rst_ready", r8, 1);
        chk("rst_valid", ov8, 0);
        chk("rst_x", ox8, 0);
        chk("rst_y", oy8, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_hold_x", ox8, 0);
        chk("rst_hold_ready", r8, 1);

        // Basic products and latency.
        run8(8'd10, 8'd20, 8'd2, lat);
        chk("t1_lat", lat, 33);
        chk("t1_x", ox8, 40);
        chk("t1_y", oy8, 160);
        @(posedge clk);
        #1;
        chk("t1_pulse_end", ov8, 0);
        chk("t1_hold_x", ox8, 40);

        run8(8'd9, 8'd27, 8'd84, lat);
        chk("t2_x", ox8, 1);
        chk("t2_y", oy8, 1);

        run8(8'd5, 8'd7, 8'd250, lat);
        chk("t3_x", ox8, 5);
        chk("t3_y", oy8, 244);

        run8(8'd5, 8'd7, 8'd0, lat);
        chk("t3_inf_lat", lat, 33);
        chk("t3_inf_x", ox8, 0);
        chk("t3_inf_y", oy8, 0);

        // in_valid held high: operands changed after accept must not leak in.
        @(negedge clk);
        x8 = 8'd10; y8 = 8'd20; z8 = 8'd2; v8 = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_busy", r8, 0);
        x8 = 8'd9; y8 = 8'd27; z8 = 8'd84;
        lat = 0;
        while (!ov8 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("t4_lat", lat, 33);
        chk("t4_x", ox8, 40);
        chk("t4_y", oy8, 160);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("t4_reaccept", r8, 0);
        chk("t4_hold_x", ox8, 40);
        chk("t4_no_pulse", ov8, 0);
        n = 5;
        while (!ov8 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t4_period", n, 34);
        chk("t4_x2", ox8, 1);
        chk("t4_y2", oy8, 1);
        @(negedge clk);
        v8 = 1'b0;
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of the third product.
        x8 = 8'd10; y8 = 8'd20; z8 = 8'd2; v8 = 1'b1;
        @(posedge clk);
        #1 v8 = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("t5_pre_x", ox8, 40);
        rst = 1'b1;
        #1;
        chk("t5_x", ox8, 0);
        chk("t5_y", oy8, 0);
        chk("t5_ready", r8, 1);
        chk("t5_valid", ov8, 0);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ov8) seen = 1'b1;
        end
        chk("t5_no_pulse", seen, 0);
        run8(8'd9, 8'd27, 8'd84, lat);
        chk("t5_after_lat", lat, 33);
        chk("t5_after_x", ox8, 1);
        chk("t5_after_y", oy8, 1);

        // Random W=8 vectors against M=251.
        repeat (20) begin
            a = 8'($urandom_range(0, 250));
            b = 8'($urandom_range(0, 250));
            c = 8'($urandom_range(0, 250));
            run8(a, b, c, lat);
            chk("r8_lat", lat, 33);
            chk("r8_x", ox8, ref_x({248'b0, a}, {248'b0, c}, 256'd251));
            chk("r8_y", oy8, ref_y({248'b0, b}, {248'b0, c}, 256'd251));
        end

        // Random W=256 vectors over P-256.
        repeat (30) begin
            ax = rnd256();
            ay = rnd256();
            az = rnd256();
            run256(ax, ay, az, lat);
            chk("r256_lat", lat, 1025);
            chk("r256_x", ox2, ref_x(ax, az, P256));
            chk("r256_y", oy2, ref_y(ay, az, P256));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
